// File: rtl/operand_sel_pkg.sv
// Shared source codes for the operand select stage.
// The 2-bit source code tells the ALU where the operand came from.
package operand_sel_pkg;

    typedef logic [1:0] src_t;

    localparam src_t SRC_REG  = 2'd0;
    localparam src_t SRC_IMM  = 2'd1;
    localparam src_t SRC_FWD  = 2'd2;
    localparam src_t SRC_ZERO = 2'd3;

endpackage

// File: rtl/fwd_match.sv
// Forwarding address compare across NFWD channels.
// Reports a hit and the lowest matching channel index, where index 0 is the youngest stage.
module fwd_match #(
    parameter int unsigned NFWD  = 2,
    parameter int unsigned RADDR = 3,
    parameter int unsigned IDXW  = 1
) (
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD*RADDR-1:0] fwd_addr,
    input  logic [RADDR-1:0]      rs_addr,
    output logic                  hit,
    output logic [IDXW-1:0]       idx
);

    // Walk from highest to lowest index so the lowest matching channel is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*RADDR +: RADDR] == rs_addr)) begin
                hit = 1'b1;
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand select stage: picks immediate, zero, forwarded or register data and registers it
// toward the ALU behind a one-deep valid/ready buffer.
module operand_sel_stage
    import operand_sel_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADDR = 3,
    parameter int unsigned NFWD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  imm_sel,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic [RADDR-1:0]      rs_addr,
    input  logic [WIDTH-1:0]      rs_data,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD*RADDR-1:0] fwd_addr,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_operand,
    output logic [1:0]            out_src,
    output logic [15:0]           fwd_count
);

    localparam int unsigned IDXW = (NFWD > 1) ? $clog2(NFWD) : 1;

    logic            fwd_hit;
    logic [IDXW-1:0] fwd_idx;
    src_t            sel_src;
    logic [WIDTH-1:0] sel_data;
    logic            accept;

    fwd_match #(
        .NFWD  (NFWD),
        .RADDR (RADDR),
        .IDXW  (IDXW)
    ) u_fwd_match (
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .rs_addr   (rs_addr),
        .hit       (fwd_hit),
        .idx       (fwd_idx)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Immediate beats the hardwired zero register, which beats forwarding.
    always_comb begin
        sel_src  = SRC_REG;
        sel_data = rs_data;
        if (imm_sel) begin
            sel_src  = SRC_IMM;
            sel_data = in_imm;
        end else if (rs_addr == '0) begin
            sel_src  = SRC_ZERO;
            sel_data = '0;
        end else if (fwd_hit) begin
            sel_src  = SRC_FWD;
            sel_data = fwd_data[fwd_idx*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_operand <= '0;
            out_src     <= SRC_REG;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_operand <= sel_data;
            out_src     <= sel_src;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count <= '0;
        end else if (accept && (sel_src == SRC_FWD) && (fwd_count != 16'hFFFF)) begin
            fwd_count <= fwd_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed bench for operand_sel_stage: a rule-level reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_operand_sel_stage;

    localparam logic [1:0] S_REG  = 2'd0;
    localparam logic [1:0] S_IMM  = 2'd1;
    localparam logic [1:0] S_FWD  = 2'd2;
    localparam logic [1:0] S_ZERO = 2'd3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        imm_sel;
    logic [15:0] in_imm;
    logic [2:0]  rs_addr;
    logic [15:0] rs_data;
    logic [1:0]  fwd_valid;
    logic [5:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_operand;
    logic [1:0]  out_src;
    logic [15:0] fwd_count;

    int n_chk = 0;
    int n_err = 0;

    operand_sel_stage #(
        .WIDTH (16),
        .RADDR (3),
        .NFWD  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imm_sel     (imm_sel),
        .in_imm      (in_imm),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_src     (out_src),
        .fwd_count   (fwd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Selection rules straight from the operand priority list.
    function automatic logic [17:0] ref_sel(input logic is, input logic [15:0] imm,
                                            input logic [2:0] a, input logic [15:0] rd,
                                            input logic [1:0] fv, input logic [5:0] fa,
                                            input logic [31:0] fd);
        if (is) return {S_IMM, imm};
        if (a == 3'd0) return {S_ZERO, 16'h0000};
        for (int i = 0; i < 2; i++)
            if (fv[i] && fa[i*3 +: 3] == a) return {S_FWD, fd[i*16 +: 16]};
        return {S_REG, rd};
    endfunction

    logic        m_valid;
    logic [15:0] m_op;
    logic [1:0]  m_src;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin
        logic [17:0] r;
        if (rst) begin
            m_valid = 1'b0;
            m_op    = 16'h0;
            m_src   = S_REG;
            m_cnt   = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            r       = ref_sel(imm_sel, in_imm, rs_addr, rs_data, fwd_valid, fwd_addr, fwd_data);
            m_valid = 1'b1;
            m_src   = r[17:16];
            m_op    = r[15:0];
            if (m_src == S_FWD && m_cnt < 65535) m_cnt++;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("model_operand", {16'd0, out_operand}, {16'd0, m_op});
        chk("model_src", {30'd0, out_src}, {30'd0, m_src});
        chk("model_count", {16'd0, fwd_count}, m_cnt);
    end

    task automatic step(input logic iv, input logic is, input logic [15:0] imm,
                        input logic [2:0] a, input logic [15:0] rd, input logic [1:0] fv,
                        input logic [2:0] a0, input logic [2:0] a1, input logic [15:0] d0,
                        input logic [15:0] d1, input logic ordy);
        in_valid  = iv;
        imm_sel   = is;
        in_imm    = imm;
        rs_addr   = a;
        rs_data   = rd;
        fwd_valid = fv;
        fwd_addr  = {a1, a0};
        fwd_data  = {d1, d0};
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [15:0] op,
                              input logic [1:0] s, input logic [15:0] cnt);
        chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, "_operand"}, {16'd0, out_operand}, {16'd0, op});
        chk({name, "_src"}, {30'd0, out_src}, {30'd0, s});
        chk({name, "_count"}, {16'd0, fwd_count}, {16'd0, cnt});
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, 16'h0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        step(0, 0, 16'h0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        expect_out("reset", 0, 16'h0000, S_REG, 16'd0);
        rst = 1'b0;

        step(1, 1, 16'h20F0, 3'd3, 16'h00FF, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        expect_out("imm", 1, 16'h20F0, S_IMM, 16'd0);
        step(1, 0, 16'h0, 3'd3, 16'h5555, 2'b00, 3'd3, 3'd3, 16'h1, 16'h2, 1);
        expect_out("reg", 1, 16'h5555, S_REG, 16'd0);
        step(1, 0, 16'h0, 3'd3, 16'h5555, 2'b11, 3'd3, 3'd3, 16'h8888, 16'h1F00, 1);
        expect_out("fwd_lowest", 1, 16'h8888, S_FWD, 16'd1);
        step(1, 0, 16'h0, 3'd0, 16'h5555, 2'b01, 3'd0, 3'd5, 16'hFFFF, 16'h0, 1);
        expect_out("zero", 1, 16'h0000, S_ZERO, 16'd1);
        step(1, 0, 16'h0, 3'd3, 16'h5555, 2'b11, 3'd2, 3'd3, 16'h8888, 16'h1F00, 1);
        expect_out("fwd_ch1", 1, 16'h1F00, S_FWD, 16'd2);
        step(1, 1, 16'h7777, 3'd3, 16'h5555, 2'b11, 3'd3, 3'd3, 16'h8888, 16'h1F00, 1);
        expect_out("imm_over_fwd", 1, 16'h7777, S_IMM, 16'd2);
        step(0, 0, 16'h0, 3'd3, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        expect_out("drain", 0, 16'h7777, S_IMM, 16'd2);

        // Stall: B is offered while A is held and must load exactly once on release.
        step(1, 0, 16'h0, 3'd5, 16'h1234, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 16'h0, 3'd5, 16'h4321, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 0);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            expect_out("stall", 1, 16'h1234, S_REG, 16'd2);
        end
        step(1, 0, 16'h0, 3'd5, 16'h4321, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        expect_out("release", 1, 16'h4321, S_REG, 16'd2);
        step(0, 0, 16'h0, 3'd5, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        expect_out("release_drain", 0, 16'h4321, S_REG, 16'd2);

        for (int k = 0; k < 3; k++)
            step(1, 0, 16'h0, 3'd4, 16'h0, 2'b01, 3'd4, 3'd0, 16'h0A0A, 16'h0, 1);
        step(0, 0, 16'h0, 3'd4, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        expect_out("pre_rst", 1, 16'h0A0A, S_FWD, 16'd5);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, 16'h0000, S_REG, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 16'h0, 3'd2, 16'h0BEE, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 0);
        expect_out("after_rst", 1, 16'h0BEE, S_REG, 16'd0);

        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 16'($urandom), 3'($urandom_range(0, 3)), 16'($urandom),
                 2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        step(0, 0, 16'h0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/operand_sel_stage.md
OPERAND_SEL_STAGE -- requirements
Module: operand_sel_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand data width in bits.
REQ-002 The block SHALL have parameter RADDR, default 3, meaning register address width.
REQ-003 The block SHALL have parameter NFWD, default 2, meaning forwarding channels (index 0 = youngest stage).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: in_valid  input  1  upstream operand request valid.
REQ-007 Port: in_ready  output  1  block can accept a request this cycle.
REQ-008 Port: imm_sel  input  1  1 = select immediate, 0 = select register path.
REQ-009 Port: in_imm  input  WIDTH  immediate value.
REQ-010 Port: rs_addr  input  RADDR  source register address.
REQ-011 Port: rs_data  input  WIDTH  register-file read data.
REQ-012 Port: fwd_valid  input  NFWD  per-channel forwarding result valid.
REQ-013 Port: fwd_addr  input  NFWD*RADDR  per-channel destination address, channel i at [i*RADDR +: RADDR].
REQ-014 Port: fwd_data  input  NFWD*WIDTH  per-channel result, channel i at [i*WIDTH +: WIDTH].
REQ-015 Port: out_valid  output  1  registered operand valid to ALU.
REQ-016 Port: out_ready  input  1  ALU accepts operand.
REQ-017 Port: out_operand  output  WIDTH  registered selected operand.
REQ-018 Port: out_src  output  2  source code: 0 REG, 1 IMM, 2 FWD, 3 ZERO.
REQ-019 Port: fwd_count  output  16  saturating count of accepted FWD-sourced requests.

Function
REQ-020 in_ready SHALL equal !out_valid || out_ready (combinational); a request is accepted when in_valid && in_ready.
REQ-021 On acceptance, out_operand/out_src SHALL load at the same clock edge; latency exactly 1 cycle; out_valid set to 1.
REQ-022 When out_valid && out_ready and no new acceptance, out_valid SHALL clear; out_operand/out_src hold their last value.
REQ-023 When out_valid && !out_ready, out_operand, out_src, out_valid SHALL hold unchanged (stall).
REQ-024 Selection priority: imm_sel=1 -> in_imm, src IMM; else rs_addr==0 -> all-zero, src ZERO; else lowest i with fwd_valid[i] && fwd_addr[i]==rs_addr -> fwd_data[i], src FWD; else rs_data, src REG.
REQ-025 Forwarding SHALL be ignored for rs_addr==0 and when imm_sel=1, even if a channel matches.
REQ-026 Multiple matching channels SHALL resolve to the lowest index only.
REQ-027 fwd_count SHALL increment by 1 per accepted FWD request and saturate at 16'hFFFF.
REQ-028 Simultaneous drain and accept SHALL keep out_valid=1 and load the new operand (full throughput, one per cycle).

Reset
REQ-029 rst SHALL asynchronously force out_valid=0, out_operand=0, out_src=0 (REG), fwd_count=0.
REQ-030 Reset mid-stall SHALL discard the held operand; first accept after release behaves as from empty.

Structure
REQ-031 Package operand_sel_pkg SHALL hold source-code constants SRC_REG/SRC_IMM/SRC_FWD/SRC_ZERO and the 2-bit source typedef.
REQ-032 Sub-module fwd_match SHALL implement the NFWD-wide address compare plus lowest-index priority encode (hit flag, index).

Verification
REQ-033 imm_sel=1, in_imm=16'h20F0, rs_data=16'h00FF, out_ready=1 -> next cycle out_operand=16'h20F0, out_src=IMM.
REQ-034 imm_sel=0, rs_addr=3, rs_data=16'h5555, no fwd valid -> out_operand=16'h5555, out_src=REG.
REQ-035 rs_addr=3, fwd ch0 addr 3 data 16'h8888, ch1 addr 3 data 16'h1F00, both valid -> 16'h8888, FWD, fwd_count+1.
REQ-036 rs_addr=0, ch0 matches addr 0 with 16'hFFFF -> out_operand=0, out_src=ZERO, fwd_count unchanged.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output held; out_ready=1 -> next request loads, no loss/duplication.
REQ-038 rst pulse while out_valid=1 and fwd_count=5 -> immediately out_valid=0, out_operand=0, fwd_count=0.
